// File: rtl/ckey_debounce.sv
// ckey_debounce: two-flop synchroniser plus per-bit debounce counter
// for raw DIP-switch lines; emits clean levels and one-cycle change pulses.
module ckey_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:1]   ckey_in,
  output logic [WIDTH:1]   ckey_out,
  output logic [WIDTH:1]   ckey_chg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH:1]  sync1_q, sync1_d;
  logic [WIDTH:1]  sync2_q, sync2_d;
  logic [WIDTH:1]  out_q, out_d;
  logic [WIDTH:1]  chg_q, chg_d;
  logic [CW-1:0]   cnt_q [WIDTH:1];
  logic [CW-1:0]   cnt_d [WIDTH:1];

  always_comb begin
    sync1_d = ckey_in;
    sync2_d = sync1_q;
    out_d   = out_q;
    chg_d   = '0;
    cnt_d   = cnt_q;
    for (int i = 1; i <= WIDTH; i++) begin
      if (sync2_q[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        out_d[i] = sync2_q[i];
        chg_d[i] = 1'b1;
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
  end

  // Reset to "all switches off" so the LED stage starts dark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      out_q   <= '1;
      chg_q   <= '0;
      for (int i = 1; i <= WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      for (int i = 1; i <= WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ckey_out = out_q;
  assign ckey_chg = chg_q;

endmodule

// File: tb/tb_ckey_debounce.sv
// tb_ckey_debounce: directed scenarios with a cycle-tagged expectation
// queue checked one time unit after every rising edge.
module tb_ckey_debounce;

  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk;
  logic         rst_n;
  logic [W:1]   ckey_in;
  logic [W:1]   ckey_out;
  logic [W:1]   ckey_chg;

  ckey_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ckey_in(ckey_in),
    .ckey_out(ckey_out),
    .ckey_chg(ckey_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [W:1] out;
    logic [W:1] chg;
    string      tag;
  } exp_t;

  exp_t q[$];
  int cyc;
  int total;
  int passed;

  task automatic exp_rel(input int a, input int b,
                         input logic [W:1] o, input logic [W:1] c,
                         input string tag);
    exp_t e;
    for (int j = a; j <= b; j++) begin
      e.cyc = cyc + j;
      e.out = o;
      e.chg = c;
      e.tag = tag;
      q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        assert ({ckey_out, ckey_chg} === {e.out, e.chg})
          passed++;
        else
          $error("FAIL %s cyc=%0d out=%b chg=%b exp out=%b chg=%b",
                 e.tag, cyc, ckey_out, ckey_chg, e.out, e.chg);
      end
    end
  endtask

  initial begin
    cyc     = 0;
    total   = 0;
    passed  = 0;
    rst_n   = 1'b0;
    ckey_in = 4'b0000;

    exp_rel(1, 3, 4'b1111, 4'b0000, "reset");
    step(3);
    rst_n   = 1'b1;
    ckey_in = 4'b1111;
    exp_rel(1, 7, 4'b1111, 4'b0000, "settle");
    step(7);

    exp_rel(1, 5, 4'b1111, 4'b0000, "press_wait");
    exp_rel(6, 6, 4'b1110, 4'b0001, "press_edge");
    exp_rel(7, 9, 4'b1110, 4'b0000, "press_after");
    ckey_in = 4'b1110;
    step(9);

    exp_rel(1, 12, 4'b1110, 4'b0000, "glitch3");
    ckey_in = 4'b1010;
    step(3);
    ckey_in = 4'b1110;
    step(9);

    exp_rel(1, 9, 4'b1110, 4'b0000, "bounce_wait");
    exp_rel(10, 10, 4'b1100, 4'b0010, "bounce_edge");
    exp_rel(11, 13, 4'b1100, 4'b0000, "bounce_after");
    ckey_in = 4'b1100;
    step(2);
    ckey_in = 4'b1110;
    step(2);
    ckey_in = 4'b1100;
    step(9);

    exp_rel(1, 5, 4'b1100, 4'b0000, "b2_rel_wait");
    exp_rel(6, 6, 4'b1110, 4'b0010, "b2_rel_edge");
    exp_rel(7, 8, 4'b1110, 4'b0000, "b2_rel_after");
    ckey_in = 4'b1110;
    step(8);

    exp_rel(1, 5, 4'b1110, 4'b0000, "simul_wait");
    exp_rel(6, 6, 4'b0111, 4'b1001, "simul_edge");
    exp_rel(7, 8, 4'b0111, 4'b0000, "simul_after");
    ckey_in = 4'b0111;
    step(8);

    exp_rel(1, 2, 4'b0111, 4'b0000, "midrst_pre");
    exp_rel(3, 4, 4'b1111, 4'b0000, "midrst_in");
    exp_rel(5, 9, 4'b1111, 4'b0000, "midrst_wait");
    exp_rel(10, 10, 4'b0011, 4'b1100, "midrst_edge");
    exp_rel(11, 13, 4'b0011, 4'b0000, "midrst_after");
    ckey_in = 4'b0011;
    step(2);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(9);

    exp_rel(1, 5, 4'b0011, 4'b0000, "b1_press_wait");
    exp_rel(6, 6, 4'b0010, 4'b0001, "b1_press_edge");
    exp_rel(7, 8, 4'b0010, 4'b0000, "b1_press_after");
    ckey_in = 4'b0010;
    step(8);

    exp_rel(1, 5, 4'b0010, 4'b0000, "b1_rel_wait");
    exp_rel(6, 6, 4'b0011, 4'b0001, "b1_rel_edge");
    exp_rel(7, 8, 4'b0011, 4'b0000, "b1_rel_after");
    ckey_in = 4'b0011;
    step(8);

    total++;
    assert (q.size() == 0)
      passed++;
    else
      $error("FAIL queue_drain left=%0d exp=0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
